// File: rtl/valid_stream_fifo.sv
// Valid-only producer stream buffered into a power-of-two FIFO and re-issued
// over a first-word-fall-through valid/ready interface; overflows are counted.
module valid_stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt,
   input  logic                       clear_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("valid_stream_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_r;
   logic             push;
   logic             pop;
   logic             drop;

   // Status comes only from the occupancy register, never from inputs.
   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == '0);
   assign count     = count_r;
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
   assign pop  = out_valid && out_ready;
   assign push = valid && (!full || pop);
   assign drop = valid && full && !pop;

   // NOTE: storage has no reset; contents are only observable behind out_valid,
   // and leaving it unreset lets the array map onto plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // A drop coinciding with a clear leaves overflow set but the counter at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_ovf) begin
            overflow <= 1'b0;
         end
         if (clear_ovf) begin
            drop_cnt <= '0;
         end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_valid_stream_fifo.sv
// Self-checking bench for valid_stream_fifo: directed vector table, corner
// sequences, and random traffic checked against a queue-based reference model.
module tb_valid_stream_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = '0;
   logic       valid = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic [7:0] drop_cnt;
   logic       clear_ovf = 1'b0;

   int errors = 0;
   int checks = 0;

   // Reference model: a queue of stored words plus overflow state.
   logic [7:0] m_q[$];
   bit         m_ovf;
   int         m_drop;

   valid_stream_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .valid     (valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clear_ovf (clear_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] d;
      logic       rdy;
      logic       clr;
      int         e_count;
      logic       e_empty;
      logic       e_full;
      logic       e_ovalid;
      logic [7:0] e_data;
      logic       e_ovf;
      int         e_drop;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model, and sample just after the edge.
   task automatic step(input logic r, input logic v, input logic [7:0] d,
                       input logic rdy, input logic clr);
      bit m_pop, m_full, m_drop_now;
      @(negedge clk);
      rst = r; valid = v; data_in = d; out_ready = rdy; clear_ovf = clr;
      if (r) begin
         m_q.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
      end else begin
         m_pop      = (m_q.size() > 0) && rdy;
         m_full     = (m_q.size() == DEPTH);
         m_drop_now = v && m_full && !m_pop;
         if (m_pop) void'(m_q.pop_front());
         if (v && !m_drop_now) m_q.push_back(d);
         if (clr) m_drop = 0;
         else if (m_drop_now && m_drop < 255) m_drop++;
         if (m_drop_now) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic compare_model(input string tag);
      check({tag, ".count"}, 32'(count), 32'(m_q.size()));
      check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
      check({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check({tag, ".out_data"}, 32'(out_data), 32'(m_q[0]));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
   endtask

   initial begin
      logic [7:0] exp_word;

      // Directed table: reset, 3 pushes, 3 pops, fill to 5, reset, empty push+ready.
      vecs.push_back('{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0});
      vecs.push_back('{0, 1, 8'h11, 0, 0, 1, 0, 0, 1, 8'h11, 0, 0});
      vecs.push_back('{0, 1, 8'h22, 0, 0, 2, 0, 0, 1, 8'h11, 0, 0});
      vecs.push_back('{0, 1, 8'h33, 0, 0, 3, 0, 0, 1, 8'h11, 0, 0});
      vecs.push_back('{0, 0, 8'h00, 1, 0, 2, 0, 0, 1, 8'h22, 0, 0});
      vecs.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h33, 0, 0});
      vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0});
      for (int i = 1; i <= 5; i++)
         vecs.push_back('{0, 1, 8'(i), 0, 0, i, 0, 0, 1, 8'h01, 0, 0});
      vecs.push_back('{1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0});
      vecs.push_back('{0, 1, 8'h5A, 1, 0, 1, 0, 0, 1, 8'h5A, 0, 0});
      vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0});

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
         check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
         check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
         check($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
         check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ovalid));
         if (vecs[i].e_ovalid)
            check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_data));
         check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
         check($sformatf("vec%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
      end

      // Fill to DEPTH, then one dropped word.
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0);
      check("fill.full", 32'(full), 32'd1);
      check("fill.count", 32'(count), 32'd16);
      step(0, 1, 8'h99, 0, 0);
      check("drop.overflow", 32'(overflow), 32'd1);
      check("drop.drop_cnt", 32'(drop_cnt), 32'd1);
      check("drop.head", 32'(out_data), 32'h00);
      check("drop.count", 32'(count), 32'd16);

      // Clear coinciding with a drop: counter cleared, flag stays set.
      step(0, 1, 8'h98, 0, 1);
      check("clr_drop.drop_cnt", 32'(drop_cnt), 32'd0);
      check("clr_drop.overflow", 32'(overflow), 32'd1);

      // Full with push and pop together: accepted, no drop.
      step(0, 1, 8'hAA, 1, 0);
      check("fullpp.count", 32'(count), 32'd16);
      check("fullpp.drop_cnt", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         exp_word = (i < DEPTH - 1) ? 8'(i + 1) : 8'hAA;
         check($sformatf("drain%0d.out_data", i), 32'(out_data), 32'(exp_word));
         step(0, 0, 8'h00, 1, 0);
      end
      check("drain.empty", 32'(empty), 32'd1);
      compare_model("drain");

      // Streaming with occupancy 1 across several pointer wraps.
      step(0, 1, 8'h40, 1, 0);
      for (int i = 1; i <= 40; i++) begin
         check($sformatf("stream%0d.out_data", i), 32'(out_data), 32'(8'h40 + 8'(i - 1)));
         step(0, 1, 8'h40 + 8'(i), 1, 0);
         check($sformatf("stream%0d.count", i), 32'(count), 32'd1);
      end

      // drop_cnt saturation, then a plain clear.
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0);
      for (int i = 0; i < 260; i++) step(0, 1, 8'hEE, 0, 0);
      check("sat.drop_cnt", 32'(drop_cnt), 32'd255);
      compare_model("sat");
      step(0, 0, 8'h00, 0, 1);
      check("clr.drop_cnt", 32'(drop_cnt), 32'd0);
      check("clr.overflow", 32'(overflow), 32'd0);
      check("clr.count", 32'(count), 32'd16);

      // Random traffic against the reference model.
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 999) == 0, $urandom_range(0, 99) < 60,
              8'($urandom), $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
         compare_model($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
